uart_rx_module: RTL

Receive side of the UART interface: deserialises 8-bit asynchronous frames from the serial input pin into parallel bytes. It is the counterpart of the transmit path, at the same baud (default 9600 bps from a 50 MHz clock). It contains its own bit-period counter, which samples each bit at mid-period. Each good byte is presented with a one-cycle done strobe to the downstream consumer, which is typically a control FSM or a FIFO.

---
 rtl/uart_pkg.sv | 41 ++++
 rtl/rx_bps_module.sv | 48 ++++
 rtl/uart_rx_module.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART receive and transmit paths: receiver FSM
// state encoding, default clock/baud constants, the bit-period counter width
// and an even-parity helper.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   -> the receiver FSM has a PARITY state (8E1 frames)
//   undefined -> 8N1 frames, no PARITY state
package uart_pkg;

  localparam int DEF_CLK_FREQ = 50_000_000;
  localparam int DEF_BAUD     = 9600;

  // Every bit-period count and comparison is carried at this width.
  localparam int CNT_W = 13;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } uart_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } uart_state_e;
`endif

  // Even parity: the parity bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/rx_bps_module.sv
// rx_bps_module
// Bit-period counter for the UART receiver. While enabled it counts
// 0..BIT_CYC-1 and wraps; while disabled it is held at 0. The sample strobe
// fires when the count reaches HALF_CYC, i.e. in the middle of each bit.
//
// Ports:
//   clk_i    in  1  system clock, rising edge
//   rst_i    in  1  synchronous active-high reset
//   en_i     in  1  count enable; clears the counter when low
//   strobe_o out 1  mid-bit sample strobe
module rx_bps_module #(
  parameter int BIT_CYC  = 5208,
  parameter int HALF_CYC = 2604
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic strobe_o
);
  import uart_pkg::*;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(HALF_CYC);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  logic [CNT_W-1:0] count_q, count_d;

  // Next count: wrap at the end of a bit period, and drop back to zero
  // whenever the receiver is not inside a frame so every frame starts at 0.
  always_comb begin
    count_d = count_q + ONE_CNT;
    if (!en_i || count_q == LAST_CNT) begin
      count_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign strobe_o = en_i && (count_q == HALF_CNT);

endmodule

// File: rtl/uart_rx_module.sv
// uart_rx_module
// UART receiver: deserialises asynchronous 8-bit frames (LSB first) from
// RX_Pin into bytes. Each bit is sampled at mid-period by rx_bps_module.
// Good bytes are presented on RX_Data with a one-cycle RX_Done strobe.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   -> 11-bit frames with an even parity bit, Parity_Err live
//   undefined -> 10-bit 8N1 frames, Parity_Err tied low
//
// Ports:
//   CLK         in   1  system clock, rising edge
//   RST         in   1  synchronous active-high reset
//   RX_Pin      in   1  asynchronous serial input, idles high
//   RX_Data     out  8  last good byte, held until the next good frame
//   RX_Done     out  1  one-cycle pulse when RX_Data updates
//   Frame_Err   out  1  one-cycle pulse when the stop bit is sampled low
//   Parity_Err  out  1  one-cycle pulse on parity mismatch
//   Busy        out  1  high whenever the FSM is not idle
module uart_rx_module #(
  parameter int CLK_FREQ = uart_pkg::DEF_CLK_FREQ,
  parameter int BAUD     = uart_pkg::DEF_BAUD
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_Pin,
  output logic [7:0] RX_Data,
  output logic       RX_Done,
  output logic       Frame_Err,
  output logic       Parity_Err,
  output logic       Busy
);
  import uart_pkg::*;

  localparam int BIT_CYC  = CLK_FREQ / BAUD;
  localparam int HALF_CYC = BIT_CYC / 2;

  logic        sync1_q, sync2_q, sync3_q;
  logic        rxLine, fallEdge, cntEn, strobe;
  uart_state_e state_q;
  logic [2:0]  bitIdx_q;
  logic [7:0]  shift_q;
  logic [7:0]  data_q;
  logic        done_q;
  logic        frameErr_q;
`ifdef UART_RX_PARITY_EN
  logic        parBad_q;
  logic        parErr_q;
`endif

  // Two flops bring RX_Pin into the clock domain; the third holds the
  // previous synchronised value for falling-edge detection. All reset to 1
  // so a reset never looks like a start edge on an idle line.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      sync3_q <= 1'b1;
    end else begin
      sync1_q <= RX_Pin;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign rxLine   = sync2_q;
  assign fallEdge = sync3_q & ~sync2_q;

  // The bit timer only runs inside a frame; in IDLE it sits at 0 so the
  // first count of START is 0, and in BREAK the line is watched directly.
  assign cntEn = (state_q != ST_IDLE) && (state_q != ST_BREAK);

  rx_bps_module #(
    .BIT_CYC (BIT_CYC),
    .HALF_CYC(HALF_CYC)
  ) u_bps (
    .clk_i   (CLK),
    .rst_i   (RST),
    .en_i    (cntEn),
    .strobe_o(strobe)
  );

  // Receiver FSM with its shift register and registered status outputs.
  // The status pulses default low every cycle so each lasts one cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      bitIdx_q   <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
      frameErr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parBad_q   <= 1'b0;
      parErr_q   <= 1'b0;
`endif
    end else begin
      done_q     <= 1'b0;
      frameErr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parErr_q   <= 1'b0;
`endif
      unique case (state_q)
        ST_IDLE: begin
          if (fallEdge) begin
            state_q <= ST_START;
          end
        end
        ST_START: begin
          // A line already back high at mid start bit was a glitch.
          if (strobe) begin
            if (rxLine) begin
              state_q <= ST_IDLE;
            end else begin
              state_q  <= ST_DATA;
              bitIdx_q <= '0;
            end
          end
        end
        ST_DATA: begin
          if (strobe) begin
            shift_q <= {rxLine, shift_q[7:1]};
            if (bitIdx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= ST_PARITY;
`else
              state_q <= ST_STOP;
`endif
            end else begin
              bitIdx_q <= bitIdx_q + 3'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (strobe) begin
            parBad_q <= (rxLine != even_parity(shift_q));
            state_q  <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          // A low stop bit outranks a parity problem, so the two error
          // pulses can never coincide.
          if (strobe) begin
            if (!rxLine) begin
              frameErr_q <= 1'b1;
              state_q    <= ST_BREAK;
`ifdef UART_RX_PARITY_EN
            end else if (parBad_q) begin
              parErr_q <= 1'b1;
              state_q  <= ST_IDLE;
`endif
            end else begin
              data_q  <= shift_q;
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
            end
          end
        end
        ST_BREAK: begin
          // Hold off new frames until the line has recovered to idle.
          if (rxLine) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign RX_Data   = data_q;
  assign RX_Done   = done_q;
  assign Frame_Err = frameErr_q;
  assign Busy      = (state_q != ST_IDLE);
`ifdef UART_RX_PARITY_EN
  assign Parity_Err = parErr_q;
`else
  assign Parity_Err = 1'b0;
`endif

endmodule
